// File: rtl/execute_mc.sv
// Execute stage: forwarding, ALU, branch/jump resolution, EX/MEM register and an
// optional iterative multiply/divide unit enabled by defining EXE_MD_EN.
module execute_mc #(
   parameter int unsigned N        = 32,
   parameter int unsigned CW_MEM_W = 7,
   parameter int unsigned RD_W     = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pipe_en,
   input  logic                flush,
   input  logic                valid_in,
   input  logic                sel_a,
   input  logic                sel_b,
   input  logic [3:0]          alu_op,
   input  logic [2:0]          branch,
   input  logic                jmp_en,
   input  logic                md_en,
   input  logic [1:0]          md_op,
   input  logic [1:0]          forwardA,
   input  logic [1:0]          forwardB,
   input  logic [N-1:0]        fwd_mem,
   input  logic [N-1:0]        fwd_wb,
   input  logic [N-1:0]        npc,
   input  logic [N-1:0]        npc4,
   input  logic [N-1:0]        r1,
   input  logic [N-1:0]        r2,
   input  logic [N-1:0]        imm,
   input  logic [CW_MEM_W-1:0] cw_mem_in,
   input  logic [RD_W-1:0]     rd_in,
   output logic                stall_req,
   output logic [N-1:0]        alu_res,
   output logic [N-1:0]        wr_data,
   output logic [N-1:0]        imm_out,
   output logic [N-1:0]        npc4_out,
   output logic [N-1:0]        jpc,
   output logic                pc_sel,
   output logic [CW_MEM_W-1:0] cw_mem,
   output logic [RD_W-1:0]     rd,
   output logic                valid_out
);

   localparam int unsigned SH_W = $clog2(N);

   logic [N-1:0]    fa, fb, op_a, op_b, alu_out, jpc_d, md_res;
   logic [SH_W-1:0] shamt;
   logic            taken, pc_sel_d, md_done;

   // Operand forwarding; code 11 falls back to the register file value
   always_comb begin
      case (forwardA)
         2'b01:   fa = fwd_wb;
         2'b10:   fa = fwd_mem;
         default: fa = r1;
      endcase
      case (forwardB)
         2'b01:   fb = fwd_wb;
         2'b10:   fb = fwd_mem;
         default: fb = r2;
      endcase
   end

   assign op_a  = sel_a ? fa : npc;
   assign op_b  = sel_b ? imm : fb;
   assign shamt = op_b[SH_W-1:0];

   // ALU: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, else pass B
   always_comb begin
      alu_out = op_b;
      case (alu_op)
         4'd0: alu_out = op_a + op_b;
         4'd1: alu_out = op_a - op_b;
         4'd2: alu_out = op_a << shamt;
         4'd3: alu_out = N'($signed(op_a) < $signed(op_b));
         4'd4: alu_out = N'(op_a < op_b);
         4'd5: alu_out = op_a ^ op_b;
         4'd6: alu_out = op_a >> shamt;
         4'd7: alu_out = $signed(op_a) >>> shamt;
         4'd8: alu_out = op_a | op_b;
         4'd9: alu_out = op_a & op_b;
         default: alu_out = op_b;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (branch)
         3'b001: taken = (fa == fb);
         3'b010: taken = (fa != fb);
         3'b011: taken = ($signed(fa) <  $signed(fb));
         3'b100: taken = ($signed(fa) >= $signed(fb));
         3'b101: taken = (fa <  fb);
         3'b110: taken = (fa >= fb);
         default: taken = 1'b0;
      endcase
   end

   assign jpc_d    = npc + (imm << 1);
   assign pc_sel_d = valid_in & (jmp_en | taken);

`ifdef EXE_MD_EN
   typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

   md_state_t       state, state_nx;
   logic [SH_W-1:0] cnt, cnt_nx;
   logic [2*N-1:0]  acc, acc_nx;
   logic [N-1:0]    md_b, md_b_nx;
   logic [1:0]      md_op_q, md_op_nx;
   logic [N:0]      mul_sum, div_rem, div_diff;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= MD_IDLE;
         cnt     <= '0;
         acc     <= '0;
         md_b    <= '0;
         md_op_q <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         acc     <= acc_nx;
         md_b    <= md_b_nx;
         md_op_q <= md_op_nx;
      end
   end

   // acc = {hi, lo}: multiply keeps {partial product, multiplier}, divide keeps
   // {remainder, dividend/quotient}. A zero divisor never subtracts, which yields
   // an all-ones quotient and leaves the dividend as remainder.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      acc_nx    = acc;
      md_b_nx   = md_b;
      md_op_nx  = md_op_q;
      stall_req = 1'b0;
      mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, md_b} : '0);
      div_rem   = acc[2*N-1:N-1];
      div_diff  = div_rem - {1'b0, md_b};
      case (state)
         MD_IDLE: begin
            if (valid_in && md_en && !flush) begin
               state_nx  = MD_RUN;
               cnt_nx    = SH_W'(N - 1);
               acc_nx    = {{N{1'b0}}, op_a};
               md_b_nx   = op_b;
               md_op_nx  = md_op;
               stall_req = 1'b1;
            end
         end
         MD_RUN: begin
            stall_req = 1'b1;
            if (flush) begin
               state_nx = MD_IDLE;
            end else begin
               if (md_op_q[1])
                  acc_nx = div_diff[N] ? {div_rem[N-1:0], acc[N-2:0], 1'b0}
                                       : {div_diff[N-1:0], acc[N-2:0], 1'b1};
               else
                  acc_nx = {mul_sum, acc[N-1:1]};
               cnt_nx = cnt - 1'b1;
               if (cnt == '0) state_nx = MD_DONE;
            end
         end
         MD_DONE: begin
            if (flush || pipe_en) state_nx = MD_IDLE;
         end
         default: state_nx = MD_IDLE;
      endcase
   end

   assign md_done = (state == MD_DONE);
   assign md_res  = md_op_q[0] ? acc[2*N-1:N] : acc[N-1:0];
`else
   logic unused_md;
   assign unused_md = ^{md_en, md_op};
   assign stall_req = 1'b0;
   assign md_done   = 1'b0;
   assign md_res    = '0;
`endif

   // EX/MEM pipeline register
   always_ff @(posedge clk) begin
      if (rst || (pipe_en && (flush || stall_req))) begin
         alu_res   <= '0;
         wr_data   <= '0;
         imm_out   <= '0;
         npc4_out  <= '0;
         jpc       <= '0;
         pc_sel    <= 1'b0;
         cw_mem    <= '0;
         rd        <= '0;
         valid_out <= 1'b0;
      end else if (pipe_en) begin
         alu_res   <= md_done ? md_res : alu_out;
         wr_data   <= fb;
         imm_out   <= imm;
         npc4_out  <= npc4;
         jpc       <= jpc_d;
         pc_sel    <= pc_sel_d;
         cw_mem    <= cw_mem_in;
         rd        <= rd_in;
         valid_out <= valid_in;
      end
   end

endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc: scoreboard of expected EX/MEM results, popped
// whenever valid_out is seen. MD cases run only when EXE_MD_EN is defined.
module tb_execute_mc;
   localparam int unsigned N  = 32;
   localparam int unsigned CW = 7;
   localparam int unsigned RW = 5;

   logic clk, rst, pipe_en, flush, valid_in, sel_a, sel_b, jmp_en, md_en;
   logic [3:0] alu_op;
   logic [2:0] branch;
   logic [1:0] md_op, forwardA, forwardB;
   logic [N-1:0] fwd_mem, fwd_wb, npc, npc4, r1, r2, imm;
   logic [CW-1:0] cw_mem_in, cw_mem;
   logic [RW-1:0] rd_in, rd;
   logic stall_req, pc_sel, valid_out;
   logic [N-1:0] alu_res, wr_data, imm_out, npc4_out, jpc;

   typedef struct {
      string        tag;
      logic [N-1:0] res;
      logic         pc;
      logic [N-1:0] jpc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   execute_mc #(.N(N), .CW_MEM_W(CW), .RD_W(RW)) dut (
      .clk(clk), .rst(rst), .pipe_en(pipe_en), .flush(flush), .valid_in(valid_in),
      .sel_a(sel_a), .sel_b(sel_b), .alu_op(alu_op), .branch(branch), .jmp_en(jmp_en),
      .md_en(md_en), .md_op(md_op), .forwardA(forwardA), .forwardB(forwardB),
      .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .npc(npc), .npc4(npc4), .r1(r1), .r2(r2),
      .imm(imm), .cw_mem_in(cw_mem_in), .rd_in(rd_in), .stall_req(stall_req),
      .alu_res(alu_res), .wr_data(wr_data), .imm_out(imm_out), .npc4_out(npc4_out),
      .jpc(jpc), .pc_sel(pc_sel), .cw_mem(cw_mem), .rd(rd), .valid_out(valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic idle_inputs();
      pipe_en = 1'b1; flush = 1'b0; valid_in = 1'b0; sel_a = 1'b1; sel_b = 1'b0;
      alu_op = 4'd0; branch = 3'b000; jmp_en = 1'b0; md_en = 1'b0; md_op = 2'b00;
      forwardA = 2'b00; forwardB = 2'b00; fwd_mem = '0; fwd_wb = '0;
      npc = '0; npc4 = '0; r1 = '0; r2 = '0; imm = '0; cw_mem_in = '0; rd_in = '0;
   endtask

   task automatic issue(input string tag, input logic [N-1:0] res, input logic pc,
                        input logic [N-1:0] jp);
      exp_t e;
      e.tag = tag; e.res = res; e.pc = pc; e.jpc = jp;
      exp_q.push_back(e);
   endtask

   // Advance one edge; any valid EX/MEM output is checked against the scoreboard head
   task automatic tick_cmp();
      exp_t e;
      @(posedge clk); #1;
      if (valid_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_valid", {31'd0, valid_out}, '0);
         end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_res"}, alu_res, e.res);
            chk({e.tag, "_pc_sel"}, {31'd0, pc_sel}, {31'd0, e.pc});
            chk({e.tag, "_jpc"}, jpc, e.jpc);
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_alu_res"}, alu_res, '0);
      chk({tag, "_wr_data"}, wr_data, '0);
      chk({tag, "_imm_out"}, imm_out, '0);
      chk({tag, "_npc4_out"}, npc4_out, '0);
      chk({tag, "_jpc"}, jpc, '0);
      chk({tag, "_pc_sel"}, {31'd0, pc_sel}, '0);
      chk({tag, "_cw_mem"}, N'(cw_mem), '0);
      chk({tag, "_rd"}, N'(rd), '0);
      chk({tag, "_valid_out"}, {31'd0, valid_out}, '0);
   endtask

   task automatic alu_op_drive(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [2:0] br, input logic [N-1:0] pc_v,
                               input logic [N-1:0] im);
      idle_inputs();
      valid_in = 1'b1; r1 = a; r2 = b; branch = br; npc = pc_v; imm = im;
   endtask

`ifdef EXE_MD_EN
   task automatic md_start(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
      idle_inputs();
      valid_in = 1'b1; md_en = 1'b1; md_op = op; r1 = a; r2 = b;
      #1;
   endtask

   task automatic run_md(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] op, input logic [N-1:0] expv, input int hold);
      int n = 0;
      logic bubbles_ok = 1'b1;
      md_start(a, b, op);
      issue(tag, expv, 1'b0, '0);
      while (stall_req === 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (valid_out !== 1'b0) bubbles_ok = 1'b0;
      end
      chk({tag, "_stall_cycles"}, 32'(n), 32'(N + 1));
      chk({tag, "_bubbles"}, {31'd0, bubbles_ok}, 32'd1);
      pipe_en = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_stall"}, {31'd0, stall_req}, '0);
         chk({tag, "_hold_valid"}, {31'd0, valid_out}, '0);
      end
      pipe_en = 1'b1;
      tick_cmp();
      idle_inputs();
   endtask
`endif

   initial begin
      idle_inputs();
      // Reset wins over a live, valid instruction
      rst = 1'b1;
      alu_op_drive(32'h1234, 32'h5678, 3'b000, 32'h100, 32'h8);
      jmp_en = 1'b1; cw_mem_in = 7'h7F; rd_in = 5'd31; npc4 = 32'h104;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_all_zero("reset");
      rst = 1'b0;
      idle_inputs();
      @(posedge clk); #1;

      // ADD with operand A forwarded from MEM
      alu_op_drive(32'd99, 32'd7, 3'b000, 32'h100, 32'h40);
      forwardA = 2'b10; fwd_mem = 32'd5; fwd_wb = 32'd1000;
      cw_mem_in = 7'h55; rd_in = 5'd9; npc4 = 32'h104;
      #1;
      chk("add_fwd_stall", {31'd0, stall_req}, '0);
      issue("add_fwd", 32'd12, 1'b0, 32'h180);
      tick_cmp();
      chk("add_fwd_valid", {31'd0, valid_out}, 32'd1);
      chk("add_fwd_wr_data", wr_data, 32'd7);
      chk("add_fwd_cw_mem", N'(cw_mem), 32'h55);
      chk("add_fwd_rd", N'(rd), 32'd9);
      chk("add_fwd_imm_out", imm_out, 32'h40);
      chk("add_fwd_npc4_out", npc4_out, 32'h104);

      // SUB: A = npc, B forwarded from WB
      alu_op_drive(32'd1, 32'd2, 3'b000, 32'h100, 32'h40);
      sel_a = 1'b0; forwardB = 2'b01; fwd_wb = 32'h30; alu_op = 4'd1;
      issue("sub_npc_wb", 32'hD0, 1'b0, 32'h180);
      tick_cmp();
      chk("sub_npc_wb_wr_data", wr_data, 32'h30);

      // XOR with immediate operand
      alu_op_drive(32'hF0F0, 32'd2, 3'b000, 32'h100, 32'h0FF0);
      sel_b = 1'b1; alu_op = 4'd5;
      issue("xor_imm", 32'hFF00, 1'b0, 32'h20E0);
      tick_cmp();

      // Forward code 11 behaves like 00
      alu_op_drive(32'h11, 32'd0, 3'b000, 32'h0, 32'h1);
      forwardA = 2'b11; fwd_mem = 32'hAAAA; fwd_wb = 32'hBBBB; sel_b = 1'b1;
      issue("fwd11", 32'h12, 1'b0, 32'h2);
      tick_cmp();

      // Branch compares: -1 vs 1
      alu_op_drive(32'hFFFF_FFFF, 32'd1, 3'b011, 32'h100, 32'h10);
      issue("blt", 32'h0, 1'b1, 32'h120);
      tick_cmp();
      alu_op_drive(32'hFFFF_FFFF, 32'd1, 3'b101, 32'h100, 32'h10);
      issue("bltu", 32'h0, 1'b0, 32'h120);
      tick_cmp();
      alu_op_drive(32'hFFFF_FFFF, 32'd1, 3'b100, 32'h100, 32'h10);
      issue("bge", 32'h0, 1'b0, 32'h120);
      tick_cmp();
      alu_op_drive(32'hFFFF_FFFF, 32'd1, 3'b110, 32'h100, 32'h10);
      issue("bgeu", 32'h0, 1'b1, 32'h120);
      tick_cmp();
      alu_op_drive(32'd5, 32'd5, 3'b001, 32'h200, 32'hFFFF_FFF8);
      issue("beq", 32'd10, 1'b1, 32'h1F0);
      tick_cmp();
      alu_op_drive(32'd5, 32'd5, 3'b010, 32'h200, 32'h8);
      issue("bne", 32'd10, 1'b0, 32'h210);
      tick_cmp();
      alu_op_drive(32'd5, 32'd6, 3'b111, 32'h200, 32'h8);
      issue("br111", 32'd11, 1'b0, 32'h210);
      tick_cmp();

      // Jump: taken when valid, suppressed when not
      alu_op_drive(32'd1, 32'd2, 3'b000, 32'hFFFF_FFF0, 32'h10);
      jmp_en = 1'b1;
      issue("jmp", 32'd3, 1'b1, 32'h10);
      tick_cmp();
      alu_op_drive(32'd1, 32'd2, 3'b000, 32'h100, 32'h10);
      jmp_en = 1'b1; valid_in = 1'b0;
      tick_cmp();
      chk("jmp_invalid_pc_sel", {31'd0, pc_sel}, '0);
      chk("jmp_invalid_valid", {31'd0, valid_out}, '0);

      // Flush turns a valid jump into a bubble
      alu_op_drive(32'd1, 32'd2, 3'b000, 32'h100, 32'h10);
      jmp_en = 1'b1; flush = 1'b1; cw_mem_in = 7'h3C;
      tick_cmp();
      chk("flush_valid", {31'd0, valid_out}, '0);
      chk("flush_pc_sel", {31'd0, pc_sel}, '0);
      chk("flush_cw_mem", N'(cw_mem), '0);

      // pipe_en low holds the EX/MEM register
      alu_op_drive(32'h1000, 32'h234, 3'b000, 32'h0, 32'h0);
      issue("pre_hold", 32'h1234, 1'b0, 32'h0);
      tick_cmp();
      alu_op_drive(32'h1, 32'h1, 3'b000, 32'h0, 32'h0);
      pipe_en = 1'b0;
      @(posedge clk); #1;
      chk("hold_alu_res", alu_res, 32'h1234);
      chk("hold_valid", {31'd0, valid_out}, 32'd1);
      pipe_en = 1'b1;
      issue("post_hold", 32'h2, 1'b0, 32'h0);
      tick_cmp();

`ifndef EXE_MD_EN
      // Without the MD unit an md_en op completes as a plain ALU op
      alu_op_drive(32'hFFFF_FFFF, 32'd2, 3'b000, 32'h0, 32'h0);
      md_en = 1'b1; md_op = 2'b00;
      #1;
      chk("md_disabled_stall", {31'd0, stall_req}, '0);
      issue("md_disabled", 32'h1, 1'b0, 32'h0);
      tick_cmp();
      chk("md_disabled_valid", {31'd0, valid_out}, 32'd1);
`else
      run_md("mul",   32'hFFFF_FFFF, 32'd2, 2'b00, 32'hFFFF_FFFE, 0);
      run_md("mulhu", 32'hFFFF_FFFF, 32'd2, 2'b01, 32'h0000_0001, 3);
      run_md("divu",  32'd100, 32'd7, 2'b10, 32'd14, 0);
      run_md("remu",  32'd100, 32'd7, 2'b11, 32'd2, 0);
      run_md("divu0", 32'd100, 32'd0, 2'b10, 32'hFFFF_FFFF, 0);
      run_md("remu0", 32'd100, 32'd0, 2'b11, 32'd100, 0);

      // Flush at RUN cycle 10: abort, bubble, no result later
      md_start(32'd123, 32'd456, 2'b00);
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
      end
      chk("mdflush_pre_stall", {31'd0, stall_req}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      chk("mdflush_stall", {31'd0, stall_req}, '0);
      chk("mdflush_valid", {31'd0, valid_out}, '0);
      idle_inputs();
      for (int i = 0; i < 40; i++) tick_cmp();
      chk("mdflush_stall_after", {31'd0, stall_req}, '0);

      // Reset at RUN cycle 5
      md_start(32'd77, 32'd3, 2'b10);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("mdrst");
      valid_in = 1'b0; md_en = 1'b0; rst = 1'b0;
      #1;
      chk("mdrst_stall", {31'd0, stall_req}, '0);
      for (int i = 0; i < 40; i++) tick_cmp();
      run_md("mul_after_rst", 32'd1000, 32'd1000, 2'b00, 32'd1000000, 0);
`endif

      idle_inputs();
      tick_cmp();
      chk("sb_drain", 32'(exp_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
- Parametrised execute stage for the RISC-V-lite pipeline, sitting between the ID/EX and EX/MEM boundaries.
- Performs single-cycle ALU ops and branch/jump resolution on forwarded operands.
- Adds an iterative multi-cycle multiply/divide unit that stalls the pipeline while it runs.
- Owns the EX/MEM pipeline register, including bubble insertion on stall and on flush.

Parameters:
- N, 32: datapath width in bits (N >= 8, power of two).
- CW_MEM_W, 7: width of the MEM/WB control word carried through the stage.
- RD_W, 5: destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pipe_en  in  1  global pipeline enable; EX/MEM register updates only when 1.
- flush  in  1  kill the instruction in EX; EX/MEM loads a bubble.
- valid_in  in  1  instruction in EX is valid.
- sel_a  in  1  operand A source: 0 = npc, 1 = r1.
- sel_b  in  1  operand B source: 0 = r2, 1 = imm.
- alu_op  in  4  ALU operation code, passed to the existing ALU.
- branch  in  3  branch type: 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 none.
- jmp_en  in  1  unconditional jump.
- md_en  in  1  instruction is multiply/divide.
- md_op  in  2  00 MUL (low N), 01 MULHU (high N), 10 DIVU, 11 REMU.
- forwardA, forwardB  in  2 each  forwarding select: 00 local, 01 fwd_wb, 10 fwd_mem, 11 treated as 00.
- fwd_mem, fwd_wb  in  N each  forwarded data from the MEM and WB stages.
- npc, npc4, r1, r2, imm  in  N each  PC, PC+4, register operands and immediate.
- cw_mem_in  in  CW_MEM_W  control word for later stages.
- rd_in  in  RD_W  destination register index.
- stall_req  out  1  combinational; high while the MD unit holds EX.
- alu_res  out  N  registered result (ALU or MD).
- wr_data  out  N  registered store data: forwarded r2.
- imm_out, npc4_out  out  N each  registered copies of imm and npc4.
- jpc  out  N  registered branch/jump target.
- pc_sel  out  1  registered redirect request.
- cw_mem  out  CW_MEM_W  registered control word.
- rd  out  RD_W  registered destination index.
- valid_out  out  1  registered valid.

Behaviour:
- Reset: every output register goes to 0 and the MD FSM goes to IDLE. Reset takes priority over flush and pipe_en, and aborts any MD operation in progress.
- Forwarding:
  - fa = forwarded r1, fb = forwarded r2, selected per forwardA/forwardB.
  - Operand A = sel_a ? fa : npc. Operand B = sel_b ? imm : fb.
  - Branch compare and wr_data use fa/fb.
- Branch and jump:
  - taken = branch condition on fa/fb; signed compares for BLT/BGE, unsigned for BLTU/BGEU.
  - jpc_d = npc + (imm << 1), computed modulo 2^N.
  - pc_sel_d = valid_in & (jmp_en | taken).
- MD FSM states and transitions:
  - IDLE -> RUN when valid_in & md_en & !flush. Operands (operand A, operand B) are latched, cnt = N-1, and stall_req = 1 in this same cycle.
  - RUN performs one radix-2 step per cycle: shift-add multiply or restoring divide, using a 2N-bit accumulator. RUN -> DONE when cnt = 0, so RUN lasts N cycles. stall_req = 1 throughout.
  - DONE: result selected by md_op and stall_req = 0. Leaves for IDLE on the cycle pipe_en = 1, when EX/MEM captures the result. Stays in DONE while pipe_en = 0.
  - flush in RUN or DONE aborts to IDLE; no result is written.
- Latency: an MD instruction occupies EX for N+2 cycles (accept, N x RUN, DONE). ALU ops take 1 cycle.
- Operand stability: upstream must hold EX inputs stable while stall_req = 1. The MD unit uses only its latched copies.
- Divide by zero: DIVU returns all ones; REMU returns the dividend.
- EX/MEM register update, in priority order:
  - rst: all zero.
  - else if pipe_en & (flush | stall_req): load a bubble. valid_out, cw_mem and pc_sel go to 0; data fields are don't-care and are zeroed.
  - else if pipe_en: capture all fields. alu_res = MD result if in DONE, else ALU output.
  - else: hold.
- pc_sel is suppressed (0) while stall_req = 1, and is also forced to 0 when valid_in = 0.

Optional Feature:
- Macro: EXE_MD_EN.
- Defined: MD FSM, datapath and stall_req as specified above.
- Undefined:
  - No MD logic is instantiated and stall_req is tied to 0.
  - md_en is ignored, so the instruction completes in 1 cycle with the ALU result.
  - Bench must check alu_res equals ALU output for an md_en = 1 op.

Test Plan:
- ALU with forwarding: forwardA = 10, fwd_mem = 5, r2 = 7, sel_a = 1, sel_b = 0, alu_op = ADD -> after one edge alu_res = 12, valid_out = 1, stall_req never high.
- BLT signed: fa = 0xFFFFFFFF, fb = 1, branch = 011, npc = 0x100, imm = 0x10 -> pc_sel = 1, jpc = 0x120. Same operands with BLTU (101) -> pc_sel = 0.
- MUL/MULHU: 0xFFFFFFFF x 2 (md_op = 00) -> stall_req high for 33 cycles, then alu_res = 0xFFFFFFFE. With md_op = 01 -> alu_res = 0x00000001. Bubbles (valid_out = 0) are emitted while stalled.
- DIVU/REMU: 100 / 7 -> 14 and 2. Divide by zero: 100 / 0 -> DIVU gives 0xFFFFFFFF, REMU gives 100.
- Flush mid-op: flush asserted at RUN cycle 10 -> FSM returns to IDLE next cycle, stall_req drops, EX/MEM shows a bubble, and no MD result ever appears.
- Reset and pipe_en hold: rst at RUN cycle 5 -> all outputs 0, FSM IDLE. Separately, pipe_en = 0 during DONE -> FSM holds DONE and the result is captured on the first edge with pipe_en = 1.
